// File: rtl/sdu_ram.sv
// rtl/sdu_ram.sv - simple dual-port block RAM, one write port and one registered read-first read port
module sdu_ram #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [AWIDTH-1:0] rd_addr,
   output logic [DWIDTH-1:0] rd_data,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              wr_en
);

   localparam int DEPTH = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DWIDTH-1:0] rd_data_d;
   logic [DWIDTH-1:0] rd_data_q;

   // Array is left without a reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = mem[rd_addr];
   end

   // Sampled on the same edge as the write, so a colliding read sees the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: tb/tb_sdu_ram.sv
// tb/tb_sdu_ram.sv - randomized self-checking bench for sdu_ram against a sparse memory model
module tb_sdu_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] rd_addr = '0;
   logic [15:0] rd_data;
   logic [15:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        wr_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] mdl [int];
   logic [15:0] exp_rd = '0;
   bit          exp_known = 1'b1;

   sdu_ram #(.DWIDTH(16), .AWIDTH(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_en   (wr_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a sparse word store; read output is the pre-write contents of the read address.
   always @(posedge reset) begin
      exp_rd = '0;
      exp_known = 1'b1;
   end

   always @(posedge clk) begin
      if (reset) begin
         exp_rd = '0;
         exp_known = 1'b1;
      end else begin
         if (mdl.exists(int'(rd_addr))) begin
            exp_rd = mdl[int'(rd_addr)];
            exp_known = 1'b1;
         end else begin
            exp_known = 1'b0;
         end
         if (wr_en) mdl[int'(wr_addr)] = wr_data;
      end
   end

   always @(negedge clk) begin
      if (exp_known) check("rd_data_model", rd_data, exp_rd);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      check("reset_state", rd_data, 16'h0000);
      reset = 1'b0;

      // Contents survive an asynchronous reset pulse.
      wr(16'd5, 16'hBEEF);
      rd_addr = 16'd5;
      tick();
      check("read_beef", rd_data, 16'hBEEF);
      #2 reset = 1'b1;
      #1 check("async_reset_clear", rd_data, 16'h0000);
      tick();
      check("reset_hold", rd_data, 16'h0000);
      reset = 1'b0;
      rd_addr = 16'd5;
      tick();
      check("beef_after_reset", rd_data, 16'hBEEF);

      for (int i = 0; i < 16; i++) wr(16'(i), 16'(i + 1));
      for (int i = 0; i < 16; i++) begin
         rd_addr = 16'(i);
         tick();
         check("seq_read", rd_data, 16'(i + 1));
      end

      wr(16'd7, 16'h1234);
      wr_addr = 16'd7;
      wr_data = 16'hFFFF;
      wr_en = 1'b0;
      tick();
      rd_addr = 16'd7;
      tick();
      check("wr_en_gating", rd_data, 16'h1234);

      wr(16'd3, 16'hAAAA);
      rd_addr = 16'd3;
      wr(16'd3, 16'h5555);
      check("collision_old", rd_data, 16'hAAAA);
      tick();
      check("collision_new", rd_data, 16'h5555);

      wr(16'hFFFF, 16'hC0DE);
      wr(16'h0000, 16'hF00D);
      rd_addr = 16'hFFFF;
      tick();
      check("addr_max", rd_data, 16'hC0DE);
      rd_addr = 16'h0000;
      tick();
      check("addr_min", rd_data, 16'hF00D);

      wr(16'd9, 16'h0042);
      reset = 1'b1;
      wr_en = 1'b1;
      wr_addr = 16'd9;
      wr_data = 16'h9999;
      tick();
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      rd_addr = 16'd9;
      #1 check("first_read_pending", rd_data, 16'h0000);
      tick();
      check("write_during_reset", rd_data, 16'h0042);

      for (int n = 0; n < 2000; n++) begin
         wr_en = ($urandom_range(0, 1) == 1);
         wr_addr = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 31));
         wr_data = 16'($urandom);
         rd_addr = ($urandom_range(0, 7) == 0) ? wr_addr : 16'($urandom_range(0, 31));
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b1;
            #1;
            check("rand_async_reset", rd_data, 16'h0000);
            tick();
            reset = 1'b0;
         end else begin
            tick();
         end
      end
      wr_en = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
